// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner selection for a shared 4-digit
// seven-segment display. Each grant owns the display for DWELL_CYCLES
// cycles, and the owner's BCD word is latched for the led_driver.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   req       in   [3:0]  request level per requester
//   req_data  in   [63:0] requester i drives [16i+15:16i]
//   grant     out  [3:0]  one-hot owner, high for the whole dwell window
//   owner     out  [1:0]  index of the current or last owner
//   new_grant out         one-cycle pulse on the first cycle of each grant
//   bcd_op    out  [15:0] latched word for the led_driver bcd input
//   busy      out         high while a window is running
module seg_display_arbiter #(
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic        new_grant,
    output logic [15:0] bcd_op,
    output logic        busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic               new_grant_q, new_grant_d;
    logic [15:0]        bcd_op_q, bcd_op_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic               win_found;
    logic [1:0]         win_idx;
    logic [1:0]         cand;
    logic               dwell_last;

    // Round-robin search: first active requester after rr_ptr, wrapping so
    // the last owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign dwell_last = (dwell_cnt_q == CNT_W'(DWELL_CYCLES - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        new_grant_d = 1'b0;
        bcd_op_d    = bcd_op_q;
        busy_d      = busy_q;
        dwell_cnt_d = dwell_cnt_q;

        if ((state_q == ST_IDLE) || dwell_last) begin
            if (win_found) begin
                // Start a fresh window; a re-grant to the same owner keeps
                // grant high without a gap but still recaptures data.
                state_d     = ST_HOLD;
                grant_d     = 4'b0001 << win_idx;
                owner_d     = win_idx;
                rr_ptr_d    = win_idx;
                new_grant_d = 1'b1;
                bcd_op_d    = req_data[{win_idx, 4'b0000} +: 16];
                busy_d      = 1'b1;
                dwell_cnt_d = '0;
            end else begin
                // No requester: release the display but keep the last word.
                state_d     = ST_IDLE;
                grant_d     = 4'b0000;
                busy_d      = 1'b0;
                dwell_cnt_d = '0;
            end
        end else begin
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 4'b0000;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd3;
            new_grant_q <= 1'b0;
            bcd_op_q    <= 16'h0000;
            busy_q      <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            new_grant_q <= new_grant_d;
            bcd_op_q    <= bcd_op_d;
            busy_q      <= busy_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign new_grant = new_grant_q;
    assign bcd_op    = bcd_op_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_seg_display_arbiter;

    localparam int unsigned DW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        new_grant;
    logic [15:0] bcd_op;
    logic        busy;

    always #5 clk = ~clk;

    seg_display_arbiter #(.DWELL_CYCLES(DW), .CNT_W(27)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .owner     (owner),
        .new_grant (new_grant),
        .bcd_op    (bcd_op),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: display is either free or owned with some cycles left.
    bit          m_act  = 1'b0;
    int          m_owner = 0;
    int          m_rr    = 3;
    int          m_left  = 0;
    logic [15:0] m_bcd   = 16'h0000;
    bit          m_new   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 50)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int pick;
        if (reset) begin
            m_act = 1'b0; m_owner = 0; m_rr = 3; m_left = 0; m_bcd = 16'h0000; m_new = 1'b0;
        end else if (m_act && m_left > 1) begin
            m_left = m_left - 1;
            m_new  = 1'b0;
        end else begin
            pick  = -1;
            m_new = 1'b0;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && req[(m_rr + k) % 4]) pick = (m_rr + k) % 4;
            if (pick >= 0) begin
                m_act = 1'b1; m_owner = pick; m_rr = pick; m_new = 1'b1; m_left = DW;
                m_bcd = 16'(req_data >> (16 * pick));
            end else begin
                m_act = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_grant", 32'(grant), m_act ? (32'd1 << m_owner) : 32'd0);
            chk("m_owner", 32'(owner), 32'(m_owner));
            chk("m_new_grant", 32'(new_grant), 32'(m_new));
            chk("m_bcd_op", 32'(bcd_op), 32'(m_bcd));
            chk("m_busy", 32'(busy), 32'(m_act));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0]  r;
    logic [63:0] d;
    int          hold;

    initial begin
        reset    = 1'b1;
        req      = 4'b1111;
        req_data = 64'h4444_3333_2222_1111;

        // 1: reset held with all requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1'b1;
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_bcd", 32'(bcd_op), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_owner", 32'(owner), 32'h0);
        end
        reset = 1'b0;
        tick();
        chk("first_grant", 32'(grant), 32'h1);

        // 2: single short request from requester 2
        do_reset();
        req = 4'b0100;
        req_data[47:32] = 16'h9538;
        tick();
        req = 4'b0000;
        chk("s2_grant", 32'(grant), 32'h4);
        chk("s2_owner", 32'(owner), 32'h2);
        chk("s2_new", 32'(new_grant), 32'h1);
        chk("s2_bcd", 32'(bcd_op), 32'h9538);
        for (int c = 1; c < 8; c++) begin
            tick();
            chk("s2_hold_grant", 32'(grant), 32'h4);
            chk("s2_hold_new", 32'(new_grant), 32'h0);
        end
        tick();
        chk("s2_end_grant", 32'(grant), 32'h0);
        chk("s2_end_busy", 32'(busy), 32'h0);
        chk("s2_end_bcd", 32'(bcd_op), 32'h9538);

        // 3: all four requesting continuously rotate in order
        do_reset();
        req_data = 64'h4444_3333_2222_1111;
        req = 4'b1111;
        tick();
        for (int w = 0; w < 5; w++) begin
            for (int c = 0; c < 8; c++) begin
                chk("s3_grant", 32'(grant), 32'd1 << (w % 4));
                chk("s3_bcd", 32'(bcd_op), 32'h1111 * 32'((w % 4) + 1));
                chk("s3_new", 32'(new_grant), (c == 0) ? 32'h1 : 32'h0);
                tick();
            end
        end

        // 4: lone requester re-granted; data captured only at window start
        do_reset();
        req_data = 64'h0;
        req_data[31:16] = 16'h0042;
        req = 4'b0010;
        tick();
        for (int c = 0; c < 20; c++) begin
            chk("s4_grant", 32'(grant), 32'h2);
            chk("s4_bcd", 32'(bcd_op), (c < 8) ? 32'h0042 : 32'h0077);
            chk("s4_new", 32'(new_grant), (c == 0 || c == 8 || c == 16) ? 32'h1 : 32'h0);
            if (c == 3) req_data[31:16] = 16'h0077;
            tick();
        end
        req = 4'b0000;

        // 5: owner drops early, another requester takes over without a gap
        do_reset();
        req = 4'b1000;
        tick();
        for (int c = 0; c < 8; c++) begin
            chk("s5_grant", 32'(grant), 32'h8);
            if (c == 2) req = 4'b0000;
            if (c == 5) req = 4'b0001;
            tick();
        end
        chk("s5_switch_grant", 32'(grant), 32'h1);
        chk("s5_switch_new", 32'(new_grant), 32'h1);
        req = 4'b0000;

        // 6: reset in the middle of a window
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        repeat (4) tick();
        chk("s6_mid_owner", 32'(owner), 32'h1);
        reset = 1'b1;
        tick();
        chk("s6_rst_grant", 32'(grant), 32'h0);
        chk("s6_rst_bcd", 32'(bcd_op), 32'h0);
        chk("s6_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        req = 4'b0110;
        tick();
        chk("s6_after_grant", 32'(grant), 32'h2);

        // Randomized traffic, checked by the model every cycle
        repeat (400) begin
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            req = r;
            hold = $urandom_range(1, 14);
            for (int h = 0; h < hold; h++) begin
                for (int j = 0; j < 16; j++) d[4*j +: 4] = 4'($urandom_range(0, 9));
                req_data = d;
                reset = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
